// File: rtl/pid_pkg.sv
// pid_pkg: shared constants and types for the PID term scheduler.
//   DEF_*_W     default widths for error, gains and integral accumulator
//   state_t     scheduler FSM encoding
//   *_SHIFT     fixed-point scaling of each term's product (P/D Q3.3, I Q0.6)
//   *_MIN/MAX   saturation limits at the default widths
package pid_pkg;
  localparam int DEF_E_W   = 6;
  localparam int DEF_K_W   = 6;
  localparam int DEF_ACC_W = 10;

  localparam int P_SHIFT = 3;
  localparam int I_SHIFT = 6;
  localparam int D_SHIFT = 3;

  localparam int ACC_MIN = -512;
  localparam int ACC_MAX = 511;
  localparam int U_MIN   = -32;
  localparam int U_MAX   = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL_P,
    ST_MUL_I,
    ST_MUL_D,
    ST_SUM
  } state_t;
endpackage

// File: rtl/pid_shift_mult.sv
// pid_shift_mult: sequential signed(A) x unsigned(B) shift-add multiplier.
//   clk, rst  clock, async active-high reset
//   ena       hold everything when low
//   load      capture a/b, clear accumulator (has priority over step)
//   step      consume one multiplier bit, LSB first
//   done      high in the cycle the final (B_W-th) bit is consumed
//   product   running sum including the current step's partial product,
//             so it is the full result in the cycle done is high
module pid_shift_mult #(
  parameter int A_W = 10,
  parameter int B_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      load,
  input  logic                      step,
  input  logic signed [A_W-1:0]     a,
  input  logic        [B_W-1:0]     b,
  output logic                      done,
  output logic signed [A_W+B_W-1:0] product
);
  localparam int P_W = A_W + B_W;
  localparam int C_W = $clog2(B_W + 1);

  // a_q carries the operand already shifted to the current bit weight and
  // b_q shifts right, so each step only looks at b_q[0].
  logic signed [P_W-1:0] a_q, acc_q, partial;
  logic        [B_W-1:0] b_q;
  logic        [C_W-1:0] cnt_q;

  always_comb begin
    partial = b_q[0] ? a_q : '0;
    product = acc_q + partial;
    done    = step && (cnt_q == C_W'(B_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (ena) begin
      if (load) begin
        a_q   <= {{B_W{a[A_W-1]}}, a};
        b_q   <= b;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (step) begin
        acc_q <= product;
        a_q   <= a_q <<< 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + C_W'(1);
      end
    end
  end
endmodule

// File: rtl/pid_term_scheduler.sv
// pid_term_scheduler: one PID sample per start, P/I/D multiplies sharing a
// single shift-add multiplier.
//   clk, rst        clock, async active-high reset
//   ena             global enable, low freezes all state
//   start           request a sample (honoured only when idle)
//   clr_int         clear integral accumulator and previous error
//   e, K_p/K_i/K_d  signed error and unsigned gains, sampled in LOAD
//   u               saturated output, held between samples
//   valid           one-cycle pulse with each new u
//   busy            sample in progress
module pid_term_scheduler
  import pid_pkg::*;
#(
  parameter int E_W   = DEF_E_W,
  parameter int K_W   = DEF_K_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  clr_int,
  input  logic signed [E_W-1:0] e,
  input  logic        [K_W-1:0] K_p,
  input  logic        [K_W-1:0] K_i,
  input  logic        [K_W-1:0] K_d,
  output logic signed [E_W-1:0] u,
  output logic                  valid,
  output logic                  busy
);
  localparam int PROD_W = ACC_W + K_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int D_W    = E_W + 1;

  localparam logic signed [ACC_W:0] ACC_HI = (ACC_W+1)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W:0] ACC_LO = (ACC_W+1)'(-(2**(ACC_W-1)));
  localparam logic signed [SUM_W-1:0] U_HI = SUM_W'(2**(E_W-1) - 1);
  localparam logic signed [SUM_W-1:0] U_LO = SUM_W'(-(2**(E_W-1)));

  state_t state_q, state_d;

  logic signed [E_W-1:0]   e_q, e_prev_q, u_pend_q, u_q, u_sat, p_base;
  logic        [K_W-1:0]   k_i_q, k_d_q;
  logic signed [ACC_W-1:0] i_acc_q, i_base, i_acc_nxt;
  logic signed [ACC_W:0]   i_sum;
  logic signed [D_W-1:0]   de_q, de_nxt;
  logic signed [SUM_W-1:0] sum_q, term_ext;
  logic signed [PROD_W-1:0] term;
  logic                    out_pend_q, valid_q;

  logic                    mul_load, mul_step, mul_done;
  logic signed [ACC_W-1:0] mul_a;
  logic        [K_W-1:0]   mul_b;
  logic signed [PROD_W-1:0] mul_prod;

  pid_shift_mult #(.A_W(ACC_W), .B_W(K_W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .load    (mul_load),
    .step    (mul_step),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Output register stage: out_pend_q keeps busy high for the cycle between
  // SUM and the valid pulse, so start is not taken until valid is showing.
  assign busy  = (state_q != ST_IDLE) || out_pend_q;
  assign valid = valid_q && ena;
  assign u     = u_q;

  // LOAD-time arithmetic. A clear in the same cycle as LOAD wins, so the
  // add and the difference are taken against zero.
  always_comb begin
    i_base = clr_int ? '0 : i_acc_q;
    p_base = clr_int ? '0 : e_prev_q;
    i_sum  = {i_base[ACC_W-1], i_base} + {{(ACC_W+1-E_W){e[E_W-1]}}, e};
    if (i_sum > ACC_HI)      i_acc_nxt = ACC_HI[ACC_W-1:0];
    else if (i_sum < ACC_LO) i_acc_nxt = ACC_LO[ACC_W-1:0];
    else                     i_acc_nxt = i_sum[ACC_W-1:0];
    de_nxt = {e[E_W-1], e} - {p_base[E_W-1], p_base};
  end

  // Per-term scaling (arithmetic shift floors) and final saturation.
  always_comb begin
    case (state_q)
      ST_MUL_P: term = mul_prod >>> P_SHIFT;
      ST_MUL_I: term = mul_prod >>> I_SHIFT;
      default:  term = mul_prod >>> D_SHIFT;
    endcase
    term_ext = {{(SUM_W-PROD_W){term[PROD_W-1]}}, term};
    if (sum_q > U_HI)      u_sat = U_HI[E_W-1:0];
    else if (sum_q < U_LO) u_sat = U_LO[E_W-1:0];
    else                   u_sat = sum_q[E_W-1:0];
  end

  // Next state and multiplier control. The next operand is loaded on the
  // same edge that finishes the previous term, so no cycle is lost.
  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    case (state_q)
      ST_IDLE: if (start && !out_pend_q) state_d = ST_LOAD;
      ST_LOAD: begin
        mul_load = 1'b1;
        mul_a    = {{(ACC_W-E_W){e[E_W-1]}}, e};
        mul_b    = K_p;
        state_d  = ST_MUL_P;
      end
      ST_MUL_P: begin
        mul_step = 1'b1;
        if (mul_done) begin
          mul_load = 1'b1;
          mul_a    = i_acc_q;
          mul_b    = k_i_q;
          state_d  = ST_MUL_I;
        end
      end
      ST_MUL_I: begin
        mul_step = 1'b1;
        if (mul_done) begin
          mul_load = 1'b1;
          mul_a    = {{(ACC_W-D_W){de_q[D_W-1]}}, de_q};
          mul_b    = k_d_q;
          state_d  = ST_MUL_D;
        end
      end
      ST_MUL_D: begin
        mul_step = 1'b1;
        if (mul_done) state_d = ST_SUM;
      end
      ST_SUM:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      e_q        <= '0;
      e_prev_q   <= '0;
      k_i_q      <= '0;
      k_d_q      <= '0;
      i_acc_q    <= '0;
      de_q       <= '0;
      sum_q      <= '0;
      u_pend_q   <= '0;
      u_q        <= '0;
      out_pend_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      valid_q <= out_pend_q;
      if (out_pend_q) begin
        u_q        <= u_pend_q;
        out_pend_q <= 1'b0;
      end
      if (clr_int) begin
        i_acc_q  <= '0;
        e_prev_q <= '0;
      end
      case (state_q)
        ST_LOAD: begin
          e_q     <= e;
          k_i_q   <= K_i;
          k_d_q   <= K_d;
          i_acc_q <= i_acc_nxt;
          de_q    <= de_nxt;
          sum_q   <= '0;
        end
        ST_MUL_P, ST_MUL_I, ST_MUL_D:
          if (mul_done) sum_q <= sum_q + term_ext;
        ST_SUM: begin
          u_pend_q   <= u_sat;
          out_pend_q <= 1'b1;
          // a finishing sample records its error even over a coincident clear
          e_prev_q   <= e_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_term_scheduler.sv
module tb_pid_term_scheduler;
  localparam int E_W = 6, K_W = 6, ACC_W = 10;

  logic clk = 1'b0;
  logic rst, ena, start, clr_int;
  logic signed [E_W-1:0] e;
  logic [K_W-1:0] K_p, K_i, K_d;
  logic signed [E_W-1:0] u;
  logic valid, busy;

  always #5 clk = ~clk;

  pid_term_scheduler #(.E_W(E_W), .K_W(K_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .clr_int(clr_int),
    .e(e), .K_p(K_p), .K_i(K_i), .K_d(K_d),
    .u(u), .valid(valid), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;
  int m_iacc = 0, m_eprev = 0;

  typedef struct {
    int e, kp, ki, kd;
    int clr_mode;  // 0 none, 1 pulse while idle, 2 coincident with LOAD
    bit rst_first;
    int exp_u;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  // Reference: one control sample computed directly from the PID rules.
  task automatic model_sample(input int ev, kp, ki, kd, input bit clr, output int uo);
    int de;
    if (clr) begin m_iacc = 0; m_eprev = 0; end
    m_iacc = clampi(m_iacc + ev, -512, 511);
    de = ev - m_eprev;
    uo = clampi(((ev * kp) >>> 3) + ((m_iacc * ki) >>> 6) + ((de * kd) >>> 3), -32, 31);
    m_eprev = ev;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; clr_int = 1'b0; ena = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_iacc = 0; m_eprev = 0;
  endtask

  // ena_mode: 0 always high, 1 random gaps, 2 low for 5 cycles inside MUL_I
  task automatic run_sample(input int ev, kp, ki, kd, clr_mode, ena_mode, exp_u,
                            input string tag);
    int hi, tot;
    bit seen;
    e = E_W'(ev); K_p = K_W'(kp); K_i = K_W'(ki); K_d = K_W'(kd);
    ena = 1'b1; start = 1'b0; clr_int = 1'b0;
    if (clr_mode == 1) begin
      clr_int = 1'b1;
      @(posedge clk); #1;
      clr_int = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    hi = 0; tot = 0; seen = 1'b0;
    while (!seen && tot < 300) begin
      if (tot == 0) begin
        ena = 1'b1;
        clr_int = (clr_mode == 2);
      end else begin
        clr_int = 1'b0;
        case (ena_mode)
          1: ena = ($urandom_range(0, 3) != 0);
          2: ena = !(tot >= 10 && tot <= 14);
          default: ena = 1'b1;
        endcase
      end
      #1;
      if (valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        tot++;
        if (ena) hi++;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_u"}, int'(u), exp_u);
      chk({tag, "_busy_at_valid"}, int'(busy), 0);
      if (ena_mode == 1) chk({tag, "_lat_en"}, hi, 21);
      else               chk({tag, "_lat"}, tot, (ena_mode == 2) ? 26 : 21);
      ena = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_pulse_once"}, int'(valid), 0);
    end
  endtask

  int xu, t1, t2, nv, tot, ev, cm;

  initial begin
    vecs[0]  = '{5,   8,  0,  0, 0, 1'b1,  5};
    vecs[1]  = '{-7,  8,  0,  0, 0, 1'b0, -7};
    vecs[2]  = '{31,  63, 0,  0, 0, 1'b1,  31};
    vecs[3]  = '{-32, 63, 0,  0, 0, 1'b0, -32};
    vecs[4]  = '{4,   0,  32, 0, 0, 1'b1,  2};
    vecs[5]  = '{4,   0,  32, 0, 0, 1'b0,  4};
    vecs[6]  = '{4,   0,  32, 0, 0, 1'b0,  6};
    vecs[7]  = '{4,   0,  32, 0, 1, 1'b0,  2};
    vecs[8]  = '{4,   0,  32, 0, 0, 1'b0,  4};
    vecs[9]  = '{-5,  0,  32, 0, 2, 1'b0, -3};
    vecs[10] = '{0,   0,  0,  8, 0, 1'b1,  0};
    vecs[11] = '{10,  0,  0,  8, 0, 1'b0,  10};
    vecs[12] = '{10,  0,  0,  8, 0, 1'b0,  0};
    vecs[13] = '{3,   0,  0,  8, 0, 1'b0, -7};

    // reset state, and start ignored while ena is low
    rst = 1'b1; ena = 1'b0; start = 1'b0; clr_int = 1'b0;
    e = '0; K_p = '0; K_i = '0; K_d = '0;
    #2;
    chk("reset_u", int'(u), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("start_while_disabled", int'(busy), 0);
    start = 1'b0; ena = 1'b1;

    // directed table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst_first) do_reset();
      model_sample(vecs[i].e, vecs[i].kp, vecs[i].ki, vecs[i].kd, vecs[i].clr_mode != 0, xu);
      run_sample(vecs[i].e, vecs[i].kp, vecs[i].ki, vecs[i].kd, vecs[i].clr_mode, 0,
                 vecs[i].exp_u, $sformatf("vec%0d", i));
    end

    // ena low for 5 cycles inside MUL_I: same result, 26 edges
    do_reset();
    model_sample(5, 8, 0, 0, 0, xu);
    run_sample(5, 8, 0, 0, 0, 2, 5, "ena_gap");

    // start held high: taken only in idle, the second one in the valid cycle
    do_reset();
    e = 6'sd5; K_p = 6'd8; K_i = '0; K_d = '0; ena = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    tot = 0; nv = 0; t1 = -1; t2 = -1;
    while (tot <= 46) begin
      start = (tot < 43);
      #1;
      if (valid) begin
        nv++;
        if (nv == 1) t1 = tot; else t2 = tot;
        chk("held_u", int'(u), 5);
        chk("held_busy", int'(busy), 0);
      end
      @(posedge clk); #1;
      tot++;
    end
    start = 1'b0;
    chk("held_first_lat", t1, 21);
    chk("held_second_lat", t2, 43);
    chk("held_count", nv, 2);

    // reset mid-sample, then integral restarts from zero
    do_reset();
    model_sample(20, 0, 32, 0, 0, xu);
    run_sample(20, 0, 32, 0, 0, 0, xu, "rst_pre");
    e = 6'sd20; K_i = 6'd32; start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_u", int'(u), 0);
    chk("rst_mid_valid", int'(valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_iacc = 0; m_eprev = 0;
    model_sample(4, 0, 32, 0, 0, xu);
    run_sample(4, 0, 32, 0, 0, 0, 2, "rst_post");

    // integral accumulator clamps at +511, then steps down from the clamp
    do_reset();
    for (int i = 0; i < 18; i++) begin
      model_sample(31, 0, 3, 0, 0, xu);
      run_sample(31, 0, 3, 0, 0, 0, xu, $sformatf("iclamp%0d", i));
    end
    chk("iclamp_top", int'(u), 23);
    model_sample(-32, 0, 3, 0, 0, xu);
    run_sample(-32, 0, 3, 0, 0, 0, 22, "iclamp_down");

    // randomized samples against the reference model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ev = int'($urandom_range(0, 63)) - 32;
      cm = ($urandom_range(0, 7) == 0) ? 2 : 0;
      t1 = int'($urandom_range(0, 63));
      t2 = int'($urandom_range(0, 63));
      nv = int'($urandom_range(0, 63));
      model_sample(ev, t1, t2, nv, cm != 0, xu);
      run_sample(ev, t1, t2, nv, cm, i % 2, xu, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
